icache_axi_master: RTL and testbench
====================================

# icache_axi_master

Bridges the instruction L1 cache's memory-side request port (I_req/I_addr/I_write/I_in/I_type, answered by I_out/I_wait) onto an AXI4 master interface. It sits directly downstream of the instruction cache inside the CPU wrapper and handles two request kinds:
- **Line refills:** 4-beat INCR read bursts.
- **Write-throughs:** single-beat strobed writes.

It holds one outstanding transaction at a time.

## Interface
- MASTER_ID, default 4'd0: value driven on ARID/AWID.
- ID_W, default 4: AXI ID width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- I_req  in  1  cache request.
- I_write  in  1  1 = write, 0 = line refill.
- I_addr  in  32  request address; refills arrive line-aligned (bits[3:0]=0).
- I_in  in  32  write data, already byte-lane aligned.
- I_type  in  `CACHE_TYPE_BITS  access size, def.svh encodings (BYTE, HWORD, WORD, BYTE_U, HWORD_U).
- I_out  out  32  refill word; equals RDATA.
- I_wait  out  1  0 = a refill beat or write completion is delivered this cycle.
- bus_err  out  1  sticky flag for an error response or protocol mismatch.
- AR channel: ARID out ID_W; ARADDR out 32; ARLEN out 4; ARSIZE out 3; ARBURST out 2; ARVALID out 1; ARREADY in 1.
- R channel: RID in ID_W; RDATA in 32; RRESP in 2; RLAST in 1; RVALID in 1; RREADY out 1.
- AW channel: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID out, with the same widths as AR; AWREADY in 1.
- W channel: WDATA out 32; WSTRB out 4; WLAST out 1; WVALID out 1; WREADY in 1.
- B channel: BID in ID_W; BRESP in 2; BVALID in 1; BREADY out 1.

## Operation
- **States:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- **IDLE:**
  - If I_req=1, latch I_addr, I_in, I_type and I_write.
  - I_write=0 goes to RD_ADDR; I_write=1 goes to WR_REQ.
  - I_req is sampled only in IDLE. Requests in any other state are ignored.
- **RD_ADDR:**
  - Drives ARVALID=1, ARADDR = latched address, ARLEN=3, ARSIZE=3'b010, ARBURST=INCR.
  - Holds until ARREADY=1, then goes to RD_DATA with the 2-bit beat counter cleared.
- **RD_DATA:**
  - RREADY=1.
  - On each RVALID cycle: I_wait=0 and I_out=RDATA in that cycle; the beat counter increments.
  - The beat with counter==3 returns to IDLE.
- **WR_REQ:**
  - AWVALID and WVALID both rise on entry, with AWLEN=0, AWSIZE=010, INCR, WLAST=1, WDATA = latched I_in.
  - Each valid drops independently after its own handshake; both handshakes may occur in the same cycle.
  - Goes to WR_RESP once both handshakes are done.
- **WSTRB:**
  - BYTE or BYTE_U: 1 << addr[1:0].
  - HWORD or HWORD_U: 4'b0011 << {addr[1],1'b0}.
  - WORD or unknown encodings: 4'b1111.
- **WR_RESP:**
  - BREADY=1.
  - On BVALID: I_wait=0 for that cycle, then return to IDLE.
- **I_wait in other cycles:**
  - IDLE: I_wait = I_req.
  - Every other state: I_wait=1 except the delivery cycles defined above.
- **bus_err:** set when any of the following occurs; cleared only by rst.
  - RRESP or BRESP is nonzero. The transfer still completes normally.
  - RID or BID differs from MASTER_ID.
  - RLAST disagrees with counter==3. The burst still ends on the 4th beat.

## Timing
- **Reset:** on a clock edge with rst=1:
  - The state machine goes to IDLE and the beat counter clears.
  - All VALID/READY outputs go to 0, bus_err goes to 0, latched registers go to 0.
  - After reset, I_wait = I_req and I_out = RDATA.
  - An in-flight AXI transaction is abandoned; the slaves share the same reset.
- **Refill latency, zero-wait slave:**
  - I_req at cycle 0.
  - ARVALID at cycle 1.
  - First I_wait=0 at cycle 2 at the earliest.
  - Back-to-back beats are delivered in cycles 2-5.
  - IDLE again at cycle 6.
- **Write latency:** AW/W at cycle 1, BVALID at cycle 2 at the earliest, I_wait=0 at that same cycle.
- **Back-to-back requests:** a new request is accepted in the first IDLE cycle after completion; no bubble beyond that.
- **Ordering:** RVALID or BVALID arriving before its address handshake is not accepted, because RREADY and BREADY stay 0 until then.
- **Outputs:** all AXI outputs are registered or decoded from state only. I_out is combinational from RDATA.

## Test plan
- **Reset:** rst=1 for 2 cycles with I_req=0 → ARVALID=AWVALID=WVALID=RREADY=BREADY=0, bus_err=0, I_wait=0.
- **Refill, zero-wait slave:** I_req, I_addr=0x0001_0040, RDATA 0xA0..0xA3 → ARADDR=0x0001_0040, ARLEN=3, I_wait low in cycles 2-5 with I_out=0xA0..0xA3, IDLE at cycle 6.
- **Refill with stalls:** ARREADY delayed 3 cycles, RVALID gapped 1-0-1-1 → I_wait low only on RVALID cycles, exactly 4 words, order preserved.
- **Byte write:** I_write=1, I_type=BYTE, I_addr=0x0000_2003, I_in=0xEF00_0000 → AWADDR=0x2003, WSTRB=4'b1000, WDATA=0xEF00_0000; I_wait low in exactly the BVALID cycle.
- **Skewed write handshakes:** WREADY at cycle 1, AWREADY at cycle 4 → WVALID drops after cycle 1, AWVALID held until cycle 4, BREADY from cycle 5.
- **Errors and mid-burst reset:** RRESP=2'b10 on beat 1 → bus_err=1 and burst still completes. Then assert rst after beat 2 of the next burst → IDLE and all valids 0 on the next edge, bus_err=0.

Source files
------------

// File: rtl/icache_axi_master.sv
// AXI4 master bridge for the instruction cache: 4-beat INCR line refills and
// single-beat strobed write-throughs, one transaction in flight at a time.

`ifndef CACHE_TYPE_BITS
`define CACHE_TYPE_BITS 3
`define CACHE_BYTE      3'b000
`define CACHE_HWORD     3'b001
`define CACHE_WORD      3'b010
`define CACHE_BYTE_U    3'b100
`define CACHE_HWORD_U   3'b101
`endif

module icache_axi_master #(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = '0
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        I_req,
    input  logic                        I_write,
    input  logic [31:0]                 I_addr,
    input  logic [31:0]                 I_in,
    input  logic [`CACHE_TYPE_BITS-1:0] I_type,
    output logic [31:0]                 I_out,
    output logic                        I_wait,
    output logic                        bus_err,

    output logic [ID_W-1:0]             ARID,
    output logic [31:0]                 ARADDR,
    output logic [3:0]                  ARLEN,
    output logic [2:0]                  ARSIZE,
    output logic [1:0]                  ARBURST,
    output logic                        ARVALID,
    input  logic                        ARREADY,

    input  logic [ID_W-1:0]             RID,
    input  logic [31:0]                 RDATA,
    input  logic [1:0]                  RRESP,
    input  logic                        RLAST,
    input  logic                        RVALID,
    output logic                        RREADY,

    output logic [ID_W-1:0]             AWID,
    output logic [31:0]                 AWADDR,
    output logic [3:0]                  AWLEN,
    output logic [2:0]                  AWSIZE,
    output logic [1:0]                  AWBURST,
    output logic                        AWVALID,
    input  logic                        AWREADY,

    output logic [31:0]                 WDATA,
    output logic [3:0]                  WSTRB,
    output logic                        WLAST,
    output logic                        WVALID,
    input  logic                        WREADY,

    input  logic [ID_W-1:0]             BID,
    input  logic [1:0]                  BRESP,
    input  logic                        BVALID,
    output logic                        BREADY
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t                        state;
    logic [31:0]                   addr_q;
    logic [31:0]                   data_q;
    logic [`CACHE_TYPE_BITS-1:0]   type_q;
    logic [1:0]                    beat_cnt;
    logic                          arvalid_q;
    logic                          rready_q;
    logic                          awvalid_q;
    logic                          wvalid_q;
    logic                          bready_q;
    logic                          bus_err_q;
    logic                          aw_fin;
    logic                          w_fin;
    logic [3:0]                    wstrb_dec;

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = 4'd3;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWVALID = awvalid_q;

    assign WDATA   = data_q;
    assign WSTRB   = wstrb_dec;
    assign WLAST   = 1'b1;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;

    assign bus_err = bus_err_q;
    assign I_out   = RDATA;

    // A channel counts as finished once its valid has dropped or is accepted now.
    assign aw_fin = !awvalid_q || AWREADY;
    assign w_fin  = !wvalid_q  || WREADY;

    always_comb begin
        wstrb_dec = 4'b1111;
        case (type_q)
            `CACHE_BYTE, `CACHE_BYTE_U:   wstrb_dec = 4'b0001 << addr_q[1:0];
            `CACHE_HWORD, `CACHE_HWORD_U: wstrb_dec = 4'b0011 << {addr_q[1], 1'b0};
            default:                      wstrb_dec = 4'b1111;
        endcase
    end

    always_comb begin
        I_wait = 1'b1;
        case (state)
            IDLE:    I_wait = I_req;
            RD_DATA: I_wait = !RVALID;
            WR_RESP: I_wait = !BVALID;
            default: I_wait = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            type_q    <= '0;
            beat_cnt  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_req) begin
                        addr_q <= I_addr;
                        data_q <= I_in;
                        type_q <= I_type;
                        if (I_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end

                RD_ADDR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (RVALID) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (RRESP != 2'b00 || RID != MASTER_ID ||
                            RLAST != (beat_cnt == 2'd3))
                            bus_err_q <= 1'b1;
                        // The local beat count, not RLAST, ends the burst.
                        if (beat_cnt == 2'd3) begin
                            rready_q <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end

                WR_REQ: begin
                    if (aw_fin && w_fin) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state     <= WR_RESP;
                    end else begin
                        if (AWREADY)
                            awvalid_q <= 1'b0;
                        if (WREADY)
                            wvalid_q <= 1'b0;
                    end
                end

                WR_RESP: begin
                    if (BVALID) begin
                        if (BRESP != 2'b00 || BID != MASTER_ID)
                            bus_err_q <= 1'b1;
                        bready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_axi_master.sv
// Directed bench for icache_axi_master: table of write vectors plus hand-built
// refill, stall, skew, error and mid-burst reset sequences.

module tb_icache_axi_master;

    localparam logic [2:0] T_BYTE    = 3'b000;
    localparam logic [2:0] T_HWORD   = 3'b001;
    localparam logic [2:0] T_WORD    = 3'b010;
    localparam logic [2:0] T_BYTE_U  = 3'b100;
    localparam logic [2:0] T_HWORD_U = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_req, I_write;
    logic [31:0] I_addr, I_in, I_out;
    logic [2:0]  I_type;
    logic        I_wait, bus_err;
    logic [3:0]  ARID, AWID, RID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_axi_master dut (
        .clk(clk), .rst(rst),
        .I_req(I_req), .I_write(I_write), .I_addr(I_addr), .I_in(I_in),
        .I_type(I_type), .I_out(I_out), .I_wait(I_wait), .bus_err(bus_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wvec_t;

    wvec_t wv[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_arvalid"}, ARVALID, 0);
        chk({tag, "_rready"},  RREADY,  0);
        chk({tag, "_awvalid"}, AWVALID, 0);
        chk({tag, "_wvalid"},  WVALID,  0);
        chk({tag, "_bready"},  BREADY,  0);
        chk({tag, "_bus_err"}, bus_err, 0);
        chk({tag, "_i_wait"},  I_wait,  0);
    endtask

    // Refill: ar_wait stall cycles before ARREADY, rv_pat bit k = RVALID in data cycle k.
    task automatic do_refill(input logic [31:0] addr, input logic [31:0] d0,
                             input int ar_wait, input logic [7:0] rv_pat,
                             input int err_beat, input logic bad_last,
                             input logic exp_err, input int exp_cycles);
        int cyc;
        int beat;
        I_req = 1'b1; I_write = 1'b0; I_addr = addr;
        smp();
        chk("rd_idle_arvalid", ARVALID, 0);
        chk("rd_idle_rready", RREADY, 0);
        chk("rd_idle_wait", I_wait, 1);
        tick();
        I_req = 1'b0;
        cyc = 1;
        for (int k = 0; k <= ar_wait; k++) begin
            ARREADY = (k == ar_wait);
            smp();
            chk("rd_arvalid", ARVALID, 1);
            chk("rd_araddr", ARADDR, addr);
            chk("rd_arlen", ARLEN, 3);
            chk("rd_arsize", ARSIZE, 3'b010);
            chk("rd_arburst", ARBURST, 2'b01);
            chk("rd_rready_early", RREADY, 0);
            chk("rd_wait_addr", I_wait, 1);
            tick();
            cyc++;
        end
        ARREADY = 1'b0;
        beat = 0;
        for (int k = 0; k < 16 && beat < 4; k++) begin
            RVALID = rv_pat[k % 8];
            RDATA  = RVALID ? d0 + beat : 32'h0;
            RLAST  = RVALID && ((beat == 3) ^ (bad_last && beat == 0));
            RRESP  = (RVALID && beat == err_beat) ? 2'b10 : 2'b00;
            smp();
            chk("rd_rready", RREADY, 1);
            chk("rd_arvalid_off", ARVALID, 0);
            chk("rd_wait_data", I_wait, !RVALID);
            if (RVALID) chk("rd_i_out", I_out, d0 + beat);
            tick();
            if (RVALID) beat++;
            cyc++;
        end
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RDATA = 32'h0;
        chk("rd_beats", beat, 4);
        chk("rd_cycles", cyc, exp_cycles);
        chk("rd_rready_off", RREADY, 0);
        chk("rd_bus_err", bus_err, exp_err);
    endtask

    // Write: AWREADY pulses in cycle aw_c, WREADY in cycle w_c, BVALID after b_delay.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] typ, input logic [3:0] strb,
                            input int aw_c, input int w_c, input int b_delay,
                            input logic [3:0] bid, input logic [1:0] bresp,
                            input logic exp_err);
        int last;
        I_req = 1'b1; I_write = 1'b1; I_addr = addr; I_in = data; I_type = typ;
        smp();
        chk("wr_idle_awvalid", AWVALID, 0);
        chk("wr_idle_wvalid", WVALID, 0);
        chk("wr_idle_bready", BREADY, 0);
        chk("wr_idle_wait", I_wait, 1);
        tick();
        I_req = 1'b0; I_write = 1'b0;
        last = (aw_c > w_c) ? aw_c : w_c;
        for (int c = 1; c <= last; c++) begin
            AWREADY = (c == aw_c);
            WREADY  = (c == w_c);
            smp();
            chk("wr_awvalid", AWVALID, c <= aw_c);
            chk("wr_wvalid", WVALID, c <= w_c);
            if (c <= aw_c) begin
                chk("wr_awaddr", AWADDR, addr);
                chk("wr_awlen", AWLEN, 0);
                chk("wr_awsize", AWSIZE, 3'b010);
                chk("wr_awburst", AWBURST, 2'b01);
            end
            if (c <= w_c) begin
                chk("wr_wdata", WDATA, data);
                chk("wr_wstrb", WSTRB, strb);
                chk("wr_wlast", WLAST, 1);
            end
            chk("wr_bready_early", BREADY, 0);
            chk("wr_wait_req", I_wait, 1);
            tick();
        end
        AWREADY = 1'b0; WREADY = 1'b0;
        for (int k = 0; k <= b_delay; k++) begin
            BVALID = (k == b_delay);
            BID    = bid;
            BRESP  = bresp;
            smp();
            chk("wr_bready", BREADY, 1);
            chk("wr_awvalid_off", AWVALID, 0);
            chk("wr_wvalid_off", WVALID, 0);
            chk("wr_wait_resp", I_wait, !BVALID);
            tick();
        end
        BVALID = 1'b0; BID = 4'h0; BRESP = 2'b00;
        chk("wr_bready_off", BREADY, 0);
        chk("wr_bus_err", bus_err, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wv[0] = '{T_BYTE,    32'h0000_2003, 32'hEF00_0000, 4'b1000};
        wv[1] = '{T_BYTE_U,  32'h0000_2001, 32'h0000_AB00, 4'b0010};
        wv[2] = '{T_HWORD,   32'h0000_2002, 32'h1234_0000, 4'b1100};
        wv[3] = '{T_HWORD_U, 32'h0000_2000, 32'h0000_5678, 4'b0011};
        wv[4] = '{T_WORD,    32'h0000_2004, 32'hDEAD_BEEF, 4'b1111};
        wv[5] = '{3'b111,    32'h0000_2006, 32'hCAFE_F00D, 4'b1111};
        wv[6] = '{T_HWORD,   32'h0000_2003, 32'h5A5A_0000, 4'b1100};

        rst = 1'b1; I_req = 1'b0; I_write = 1'b0; I_addr = '0; I_in = '0; I_type = '0;
        ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        smp();
        chk_quiet("reset");
        RDATA = 32'h1357_9BDF;
        #1;
        chk("reset_i_out", I_out, 32'h1357_9BDF);
        RDATA = 32'h0;
        tick();

        do_refill(32'h0001_0040, 32'hA0, 0, 8'hFF, -1, 1'b0, 1'b0, 6);
        do_refill(32'h0002_0080, 32'hB0, 3, 8'h1D, -1, 1'b0, 1'b0, 10);

        for (int i = 0; i < 7; i++)
            do_write(wv[i].addr, wv[i].data, wv[i].typ, wv[i].strb, 1, 1, 0, 4'h0, 2'b00, 1'b0);

        do_write(32'h0000_3000, 32'h1122_3344, T_WORD, 4'hF, 4, 1, 2, 4'h0, 2'b00, 1'b0);
        do_write(32'h0000_3010, 32'h5566_7788, T_WORD, 4'hF, 1, 3, 0, 4'h0, 2'b00, 1'b0);

        do_refill(32'h0000_0040, 32'hC0, 0, 8'hFF, 1, 1'b0, 1'b1, 6);

        // Next burst is cut short by reset after two beats.
        I_req = 1'b1; I_write = 1'b0; I_addr = 32'h0000_0100;
        tick();
        I_req = 1'b0;
        ARREADY = 1'b1;
        smp();
        chk("mr_arvalid", ARVALID, 1);
        tick();
        ARREADY = 1'b0;
        for (int b = 0; b < 2; b++) begin
            RVALID = 1'b1; RDATA = 32'hD0 + b; RLAST = 1'b0;
            smp();
            chk("mr_wait", I_wait, 0);
            chk("mr_i_out", I_out, 32'hD0 + b);
            tick();
        end
        RVALID = 1'b0; RDATA = 32'h0;
        rst = 1'b1;
        smp();
        chk("mr_rready_before", RREADY, 1);
        tick();
        rst = 1'b0;
        smp();
        chk_quiet("mr_after");
        tick();

        do_write(32'h0000_4000, 32'h0BAD_0BAD, T_WORD, 4'hF, 1, 1, 1, 4'h5, 2'b00, 1'b1);
        do_reset();
        do_refill(32'h0000_0200, 32'hE0, 1, 8'hFF, -1, 1'b1, 1'b1, 7);
        do_reset();
        do_write(32'h0000_4004, 32'h0000_00FF, T_BYTE, 4'b0001, 1, 1, 0, 4'h0, 2'b11, 1'b1);
        do_reset();
        smp();
        chk("final_bus_err", bus_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
